// File: rtl/i2c_bus_arbiter.sv
// rtl/i2c_bus_arbiter.sv - transaction-granular two-requester arbiter in front of one I2C master engine
// Optional: I2C_ARB_AUTO_STOP_ON_NACK_EN issues a STOP before forwarding a WRITE NACK.
module i2c_bus_arbiter #(
    parameter int HOLD_TIMEOUT = 4095,
    parameter int CNT_W        = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [1:0]  cmd_valid,
    input  logic [5:0]  cmd_op,
    input  logic [15:0] cmd_wdata,
    output logic [1:0]  cmd_ready,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_nack,
    output logic        m_cmd_valid,
    output logic [2:0]  m_cmd_op,
    output logic [7:0]  m_cmd_wdata,
    input  logic        m_cmd_ready,
    input  logic        m_rsp_valid,
    input  logic [7:0]  m_rsp_rdata,
    input  logic        m_rsp_nack,
    output logic        bus_open,
    output logic        err_timeout,
    input  logic        err_clr
);

    localparam logic [2:0] OP_START     = 3'd0;
    localparam logic [2:0] OP_STOP      = 3'd1;
    localparam logic [2:0] OP_WRITE     = 3'd2;
    localparam logic [2:0] OP_READ_NACK = 3'd4;
    localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(HOLD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANTED,
        S_ISSUE,
        S_WAIT_RSP,
        S_RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [2:0]       op_q, op_d;
    logic [7:0]       wdata_q, wdata_d;
    logic             self_q, self_d;
    logic             nack_stop_q, nack_stop_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [1:0]       rsp_valid_q, rsp_valid_d;
    logic [7:0]       rsp_rdata_q, rsp_rdata_d;
    logic             rsp_nack_q, rsp_nack_d;
    logic             bus_open_q, bus_open_d;
    logic             err_q, err_d;

    logic       owner_req, owner_cmd, accept, timeout, set_err, win;
    logic [1:0] owner_oh;
    logic [2:0] owner_op;
    logic [7:0] owner_wdata;

    assign owner_oh    = owner_q ? 2'b10 : 2'b01;
    assign owner_req   = req[owner_q];
    assign owner_cmd   = cmd_valid[owner_q];
    assign owner_op    = owner_q ? cmd_op[5:3] : cmd_op[2:0];
    assign owner_wdata = owner_q ? cmd_wdata[15:8] : cmd_wdata[7:0];
    assign accept      = (state_q == S_GRANTED) && owner_req && owner_cmd;
    assign timeout     = (state_q == S_GRANTED) && !accept && (timer_q == LIMIT);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        last_d      = last_q;
        owner_d     = owner_q;
        op_d        = op_q;
        wdata_d     = wdata_q;
        self_d      = self_q;
        nack_stop_d = nack_stop_q;
        timer_d     = timer_q;
        rsp_valid_d = 2'b00;
        rsp_rdata_d = rsp_rdata_q;
        rsp_nack_d  = rsp_nack_q;
        bus_open_d  = bus_open_q;
        set_err     = 1'b0;
        win         = 1'b0;
        cmd_ready   = accept ? owner_oh : 2'b00;

        case (state_q)
            S_IDLE: begin
                if (|req) begin
                    win     = (req == 2'b11) ? ~last_q : req[1];
                    owner_d = win;
                    last_d  = win;
                    gnt_d   = win ? 2'b10 : 2'b01;
                    timer_d = '0;
                    state_d = S_GRANTED;
                end
            end
            S_GRANTED: begin
                if (!owner_req || timeout) begin
                    set_err = timeout;
                    gnt_d   = 2'b00;
                    timer_d = '0;
                    state_d = bus_open_q ? S_RELEASE : S_IDLE;
                end else if (accept) begin
                    timer_d = '0;
                    op_d    = owner_op;
                    wdata_d = owner_wdata;
                    self_d  = 1'b0;
                    if (owner_op > OP_READ_NACK) begin
                        rsp_valid_d = owner_oh;
                        rsp_nack_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            S_ISSUE: begin
                if (m_cmd_ready) state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (m_rsp_valid) begin
                    if (op_q == OP_START) bus_open_d = 1'b1;
                    if (op_q == OP_STOP)  bus_open_d = 1'b0;
                    if (self_q) begin
                        // Arbiter-owned STOP: swallow the response, NACK included.
                        self_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
`ifdef I2C_ARB_AUTO_STOP_ON_NACK_EN
                        if (nack_stop_q) begin
                            nack_stop_d = 1'b0;
                            rsp_valid_d = owner_oh;
                            rsp_rdata_d = m_rsp_rdata;
                            rsp_nack_d  = 1'b1;
                            state_d     = S_GRANTED;
                        end else if (op_q == OP_WRITE && m_rsp_nack) begin
                            nack_stop_d = 1'b1;
                            op_d        = OP_STOP;
                            state_d     = S_ISSUE;
                        end else begin
                            rsp_valid_d = owner_oh;
                            rsp_rdata_d = m_rsp_rdata;
                            rsp_nack_d  = m_rsp_nack;
                            state_d     = S_GRANTED;
                        end
`else
                        rsp_valid_d = owner_oh;
                        rsp_rdata_d = m_rsp_rdata;
                        rsp_nack_d  = m_rsp_nack;
                        state_d     = S_GRANTED;
`endif
                    end
                end
            end
            S_RELEASE: begin
                op_d    = OP_STOP;
                self_d  = 1'b1;
                state_d = S_ISSUE;
            end
            default: state_d = S_IDLE;
        endcase

        err_d = set_err ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            gnt_q       <= 2'b00;
            last_q      <= 1'b1;
            owner_q     <= 1'b0;
            op_q        <= 3'd0;
            wdata_q     <= 8'd0;
            self_q      <= 1'b0;
            nack_stop_q <= 1'b0;
            timer_q     <= '0;
            rsp_valid_q <= 2'b00;
            rsp_rdata_q <= 8'd0;
            rsp_nack_q  <= 1'b0;
            bus_open_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            wdata_q     <= wdata_d;
            self_q      <= self_d;
            nack_stop_q <= nack_stop_d;
            timer_q     <= timer_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_nack_q  <= rsp_nack_d;
            bus_open_q  <= bus_open_d;
            err_q       <= err_d;
        end
    end

    // The engine shares rst, so the command request is dropped without waiting for an edge.
    assign m_cmd_valid = (state_q == S_ISSUE) && !rst;
    assign m_cmd_op    = op_q;
    assign m_cmd_wdata = wdata_q;
    assign gnt         = gnt_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_nack    = rsp_nack_q;
    assign bus_open    = bus_open_q;
    assign err_timeout = err_q;

endmodule
